// File: rtl/frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_pkg
// Shared definitions for the frame-buffer write and read controllers:
//   - SLOT_BITS / fb_slot_t : frame-buffer slot index (four slots)
//   - fb_state_e            : controller FSM state encoding
// No ports; imported with "import frame_buf_pkg::*;".
// -----------------------------------------------------------------------------
package frame_buf_pkg;

    localparam int SLOT_BITS = 2;

    typedef logic [SLOT_BITS-1:0] fb_slot_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACK       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_BURST     = 3'd3,
        ST_DONE      = 3'd4
    } fb_state_e;

endpackage : frame_buf_pkg

// File: rtl/frame_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// frame_write_ctrl_if
// Burst-write bus between the frame write controller and the memory controller.
//   wr_burst_req       controller -> memory  burst request
//   wr_burst_len       controller -> memory  beats in burst (10 bits)
//   wr_burst_addr      controller -> memory  burst start word address
//   wr_burst_data      controller -> memory  beat data
//   wr_burst_data_req  memory -> controller  one beat accepted this cycle
//   wr_burst_finish    memory -> controller  one-cycle burst-complete pulse
// Modports: master (frame write controller), slave (memory controller).
// -----------------------------------------------------------------------------
interface frame_write_ctrl_if #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 25
) ();

    logic                     wr_burst_req;
    logic [9:0]               wr_burst_len;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_data_req;
    logic                     wr_burst_finish;

    modport master (
        output wr_burst_req,
        output wr_burst_len,
        output wr_burst_addr,
        output wr_burst_data,
        input  wr_burst_data_req,
        input  wr_burst_finish
    );

    modport slave (
        input  wr_burst_req,
        input  wr_burst_len,
        input  wr_burst_addr,
        input  wr_burst_data,
        output wr_burst_data_req,
        output wr_burst_finish
    );

endinterface : frame_write_ctrl_if

// File: rtl/frame_write_ctrl.sv
// -----------------------------------------------------------------------------
// frame_write_ctrl
// Moves one video frame from a show-ahead pixel FIFO into a frame-buffer slot
// as a sequence of memory write bursts.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   write_req         frame-write request, held until write_req_ack
//   write_addr_index  target frame-buffer slot
//   write_req_ack     one-cycle acknowledge
//   fifo_rdusedw      words available in the pixel FIFO
//   fifo_rd_en        pixel FIFO pop (follows wr_burst_data_req during a burst)
//   fifo_rd_data      pixel FIFO head word
//   mem               burst-write bus (frame_write_ctrl_if.master)
//   busy              frame in progress
//   frame_done        one-cycle pulse when the last burst of a frame completes
//   frame_abort       one-cycle pulse when a frame is abandoned for a new one
//
// Build option: define FRAME_WRITE_ABORT_EN to let a new write_req seen between
// bursts abandon the current frame and restart on the new slot. Without it
// frame_abort stays 0 and requests are only taken in IDLE.
// -----------------------------------------------------------------------------
module frame_write_ctrl
    import frame_buf_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 25,
    parameter int BURST_LEN     = 64,
    parameter int FRAME_SIZE    = 1920*1080*16/MEM_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_req,
    input  fb_slot_t                 write_addr_index,
    output logic                     write_req_ack,
    input  logic [10:0]              fifo_rdusedw,
    output logic                     fifo_rd_en,
    input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
    frame_write_ctrl_if.master       mem,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_abort
);

    // Offset within a slot occupies the address bits below the slot index.
    localparam int OFF_BITS = ADDR_BITS - SLOT_BITS;
    localparam logic [OFF_BITS-1:0] FRAME_SIZE_C = OFF_BITS'(FRAME_SIZE);
    localparam logic [OFF_BITS-1:0] BURST_OFF_C  = OFF_BITS'(BURST_LEN);
    localparam logic [9:0]          BURST_LEN_C  = 10'(BURST_LEN);

    fb_state_e             state_q;
    fb_slot_t              slot_q;
    logic [OFF_BITS-1:0]   offset_q;
    logic                  ack_q;
    logic                  req_q;
    logic [9:0]            len_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  abort_q;

    logic [OFF_BITS-1:0]   remain_d;
    logic [9:0]            len_d;
    logic [OFF_BITS-1:0]   offset_d;

    // Next burst length and post-burst offset; the min is done at offset width
    // so a large remainder never wraps in the 10-bit length.
    always_comb begin
        remain_d = FRAME_SIZE_C - offset_q;
        if (remain_d >= BURST_OFF_C) begin
            len_d = BURST_LEN_C;
        end else begin
            len_d = remain_d[9:0];
        end
        offset_d = offset_q + OFF_BITS'(len_q);
    end

    // Frame FSM with offset counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            slot_q   <= {SLOT_BITS{1'b0}};
            offset_q <= {OFF_BITS{1'b0}};
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            len_q    <= 10'd0;
            addr_q   <= {ADDR_BITS{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (write_req) begin
                        slot_q   <= write_addr_index;
                        offset_q <= {OFF_BITS{1'b0}};
                        ack_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_ACK;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
`ifdef FRAME_WRITE_ABORT_EN
                    // A new request between bursts abandons this frame.
                    if (write_req) begin
                        abort_q  <= 1'b1;
                        slot_q   <= write_addr_index;
                        offset_q <= {OFF_BITS{1'b0}};
                        ack_q    <= 1'b1;
                        state_q  <= ST_ACK;
                    end else
`endif
                    if (fifo_rdusedw >= {1'b0, len_d}) begin
                        len_q   <= len_d;
                        addr_q  <= {slot_q, offset_q};
                        req_q   <= 1'b1;
                        state_q <= ST_BURST;
                    end else begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_BURST: begin
                    if (mem.wr_burst_finish) begin
                        req_q    <= 1'b0;
                        offset_q <= offset_d;
                        if (offset_d == FRAME_SIZE_C) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT_DATA;
                        end
                    end else begin
                        state_q <= ST_BURST;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pops track the controller's beat strobe directly so no beat is lost or
    // duplicated; forced low whenever no burst is active (including reset).
    assign fifo_rd_en        = (state_q == ST_BURST) && mem.wr_burst_data_req;
    assign mem.wr_burst_data = fifo_rd_data;
    assign mem.wr_burst_req  = req_q;
    assign mem.wr_burst_len  = len_q;
    assign mem.wr_burst_addr = addr_q;
    assign write_req_ack     = ack_q;
    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign frame_abort       = abort_q;

endmodule : frame_write_ctrl
